// File: rtl/reg_file_sb_if.sv
// Bundle between decode/write-back and the register file with load-use scoreboard.
// master = decode/write-back side, slave = register file.
interface reg_file_sb_if #(
    parameter int D_SIZE = 32
);
    logic              wb_we;
    logic [2:0]        wb_dest;
    logic [D_SIZE-1:0] wb_data;
    logic              wb_load;
    logic              rd_en_a;
    logic [2:0]        rd_addr_a;
    logic [D_SIZE-1:0] rd_data_a;
    logic              rd_en_b;
    logic [2:0]        rd_addr_b;
    logic [D_SIZE-1:0] rd_data_b;
    logic              issue_load;
    logic [2:0]        issue_dest;
    logic              stall;
    logic [3:0]        pend_cnt;

    modport master (
        output wb_we, wb_dest, wb_data, wb_load,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output issue_load, issue_dest,
        input  rd_data_a, rd_data_b, stall, pend_cnt
    );

    modport slave (
        input  wb_we, wb_dest, wb_data, wb_load,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  issue_load, issue_dest,
        output rd_data_a, rd_data_b, stall, pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// 8-entry register file with write-through read ports and a per-register load scoreboard.
// Optional macro R0_ZERO_EN: register 0 hardwired to zero and never marked pending.
module rf_rd_port #(
    parameter int D_SIZE = 32,
    parameter int NREGS  = 8
) (
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [2:0]                   addr_i,
    input  logic [NREGS-1:0][D_SIZE-1:0] regs_i,
    input  logic [NREGS-1:0]             pending_i,
    input  logic                         wb_we_i,
    input  logic                         wb_load_i,
    input  logic [2:0]                   wb_dest_i,
    input  logic [D_SIZE-1:0]            wb_data_i,
    output logic [D_SIZE-1:0]            data_o,
    output logic                         hit_o
);
    logic byp;
    logic zero_addr;

    always_comb begin
        byp = wb_we_i && (wb_dest_i == addr_i);
`ifdef R0_ZERO_EN
        zero_addr = (addr_i == 3'd0);
`else
        zero_addr = 1'b0;
`endif
        data_o = '0;
        // During reset the array still holds stale values, so only the bypass is visible
        if (zero_addr)    data_o = '0;
        else if (byp)     data_o = wb_data_i;
        else if (rst_ni)  data_o = regs_i[addr_i];
        // A completing load to this address satisfies the read through the bypass
        hit_o = rst_ni && en_i && pending_i[addr_i] && !(byp && wb_load_i);
    end
endmodule

module reg_file_sb #(
    parameter int D_SIZE = 32,
    parameter int NREGS  = 8
) (
    input logic           clk,
    input logic           rst,
    reg_file_sb_if.slave  bus
);
    localparam int NPORTS = 2;

    logic [NREGS-1:0][D_SIZE-1:0]  regs_q, regs_d;
    logic [NREGS-1:0]              pending_q, pending_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [NPORTS-1:0]             rd_en;
    logic [NPORTS-1:0][2:0]        rd_addr;
    logic [NPORTS-1:0][D_SIZE-1:0] rd_data;
    logic [NPORTS-1:0]             hit;
    logic                          stall;
    logic                          we_eff;
    logic [NREGS-1:0]              set_vec, clr_vec;

    function automatic logic [3:0] popcnt(input logic [NREGS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    assign rd_en   = {bus.rd_en_b, bus.rd_en_a};
    assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

    for (genvar g = 0; g < NPORTS; g++) begin : g_rd
        rf_rd_port #(.D_SIZE(D_SIZE), .NREGS(NREGS)) u_port (
            .rst_ni    (rst),
            .en_i      (rd_en[g]),
            .addr_i    (rd_addr[g]),
            .regs_i    (regs_q),
            .pending_i (pending_q),
            .wb_we_i   (bus.wb_we),
            .wb_load_i (bus.wb_load),
            .wb_dest_i (bus.wb_dest),
            .wb_data_i (bus.wb_data),
            .data_o    (rd_data[g]),
            .hit_o     (hit[g])
        );
    end

    assign stall         = |hit;
    assign bus.stall     = stall;
    assign bus.rd_data_a = rd_data[0];
    assign bus.rd_data_b = rd_data[1];
    assign bus.pend_cnt  = cnt_q;

    always_comb begin
`ifdef R0_ZERO_EN
        we_eff = bus.wb_we && (bus.wb_dest != 3'd0);
`else
        we_eff = bus.wb_we;
`endif
        regs_d = regs_q;
        if (we_eff) regs_d[bus.wb_dest] = bus.wb_data;

        set_vec = '0;
        clr_vec = '0;
        if (bus.issue_load && !stall) set_vec[bus.issue_dest] = 1'b1;
        if (bus.wb_we && bus.wb_load) clr_vec[bus.wb_dest] = 1'b1;
`ifdef R0_ZERO_EN
        set_vec[0] = 1'b0;
`endif
        // Set applied after clear: a new load to the same register stays in flight
        pending_d = (pending_q & ~clr_vec) | set_vec;
        cnt_d     = popcnt(pending_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q    <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, bypass, load-use stall, collisions, R0 handling.
module tb_reg_file_sb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_sb_if #(.D_SIZE(32)) bus ();

    reg_file_sb #(.D_SIZE(32), .NREGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we      = 1'b0;
        bus.wb_dest    = 3'd0;
        bus.wb_data    = 32'd0;
        bus.wb_load    = 1'b0;
        bus.rd_en_a    = 1'b0;
        bus.rd_addr_a  = 3'd0;
        bus.rd_en_b    = 1'b0;
        bus.rd_addr_b  = 3'd0;
        bus.issue_load = 1'b0;
        bus.issue_dest = 3'd0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 8; i++) begin
            idle();
            bus.wb_we   = 1'b1;
            bus.wb_dest = i[2:0];
            bus.wb_data = 32'h100 + i;
            tick();
        end
        idle();
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd3;
        tick();
        idle();
        bus.rd_addr_a = 3'd5;
        #1;
        checks++;
        if (bus.rd_data_a !== 32'h105) begin
            failures++;
            $display("FAIL pre_reset_r5 got=%h exp=%h", bus.rd_data_a, 32'h105);
        end
        checks++;
        if (bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL pre_reset_cnt got=%0d exp=1", bus.pend_cnt);
        end
        // reset cycle with simultaneous write/issue and a live read of a pending reg
        rst = 1'b0;
        bus.wb_we      = 1'b1;
        bus.wb_dest    = 3'd1;
        bus.wb_data    = 32'hAAAA;
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd6;
        bus.rd_en_a    = 1'b1;
        bus.rd_addr_a  = 3'd3;
        bus.rd_addr_b  = 3'd2;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL in_reset_stall got=%b exp=0", bus.stall);
        end
        checks++;
        if (bus.rd_data_b !== 32'd0) begin
            failures++;
            $display("FAIL in_reset_rd got=%h exp=0", bus.rd_data_b);
        end
        tick();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr_a = i[2:0];
            #1;
            checks++;
            if (bus.rd_data_a !== 32'd0) begin
                failures++;
                $display("FAIL post_reset_r%0d got=%h exp=0", i, bus.rd_data_a);
            end
        end
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = 3'd3;
        bus.rd_en_b   = 1'b1;
        bus.rd_addr_b = 3'd6;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL post_reset_sb stall=%b cnt=%0d exp stall=0 cnt=0", bus.stall, bus.pend_cnt);
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        bus.wb_we     = 1'b1;
        bus.wb_dest   = 3'd3;
        bus.wb_data   = 32'hDEADBEEF;
        bus.rd_addr_a = 3'd3;
        bus.rd_addr_b = 3'd2;
        #1;
        checks++;
        if (bus.rd_data_a !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_bypass got=%h exp=deadbeef", bus.rd_data_a);
        end
        checks++;
        if (bus.rd_data_b !== 32'd0) begin
            failures++;
            $display("FAIL wr_other_port got=%h exp=0", bus.rd_data_b);
        end
        tick();
        bus.wb_we = 1'b0;
        bus.rd_addr_b = 3'd3;
        #1;
        checks++;
        if (bus.rd_data_a !== 32'hDEADBEEF || bus.rd_data_b !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_stored a=%h b=%h exp=deadbeef", bus.rd_data_a, bus.rd_data_b);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd5;
        tick();
        idle();
        bus.rd_en_b   = 1'b1;
        bus.rd_addr_b = 3'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lu_stall stall=%b cnt=%0d exp stall=1 cnt=1", bus.stall, bus.pend_cnt);
        end
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd5;
        bus.wb_data = 32'h1234;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_data_b !== 32'h1234) begin
            failures++;
            $display("FAIL lu_complete stall=%b data=%h exp stall=0 data=1234", bus.stall, bus.rd_data_b);
        end
        tick();
        bus.wb_we   = 1'b0;
        bus.wb_load = 1'b0;
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd0 || bus.stall !== 1'b0 || bus.rd_data_b !== 32'h1234) begin
            failures++;
            $display("FAIL lu_after cnt=%0d stall=%b data=%h exp 0/0/1234", bus.pend_cnt, bus.stall, bus.rd_data_b);
        end
        idle();
    endtask

    task automatic test_collision();
        idle();
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd2;
        tick();
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd2;
        bus.wb_data = 32'h55;
        tick();
        idle();
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = 3'd2;
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL coll_set_wins cnt=%0d stall=%b exp cnt=1 stall=1", bus.pend_cnt, bus.stall);
        end
        checks++;
        if (bus.rd_data_a !== 32'h55) begin
            failures++;
            $display("FAIL coll_data got=%h exp=55", bus.rd_data_a);
        end
        idle();
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd2;
        bus.wb_data = 32'h66;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL coll_drain cnt=%0d exp=0", bus.pend_cnt);
        end
    endtask

    task automatic test_stall_gating();
        idle();
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd4;
        tick();
        bus.issue_dest = 3'd6;
        bus.rd_en_a    = 1'b1;
        bus.rd_addr_a  = 3'd4;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL gate_stall got=%b exp=1", bus.stall);
        end
        tick();
        bus.issue_load = 1'b0;
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL gate_issue_dropped cnt=%0d exp=1", bus.pend_cnt);
        end
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b0;
        bus.wb_dest = 3'd4;
        bus.wb_data = 32'h77;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL gate_nonload_write stall=%b exp=1", bus.stall);
        end
        tick();
        bus.wb_we = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.pend_cnt !== 4'd1 || bus.rd_data_a !== 32'h77) begin
            failures++;
            $display("FAIL gate_still_pending stall=%b cnt=%0d data=%h exp 1/1/77", bus.stall, bus.pend_cnt, bus.rd_data_a);
        end
        // wb_load without wb_we must not clear
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd4;
        tick();
        bus.wb_load   = 1'b0;
        bus.rd_en_a   = 1'b0;
        bus.rd_en_b   = 1'b1;
        bus.rd_addr_b = 3'd6;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL gate_r6_clear stall=%b cnt=%0d exp stall=0 cnt=1", bus.stall, bus.pend_cnt);
        end
        idle();
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd4;
        bus.wb_data = 32'h78;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i <= 3; i++) begin
            bus.issue_load = 1'b1;
            bus.issue_dest = i[2:0];
            tick();
            checks++;
            if (bus.pend_cnt !== i[3:0]) begin
                failures++;
                $display("FAIL b2b_cnt%0d got=%0d exp=%0d", i, bus.pend_cnt, i);
            end
        end
        // complete reg 1 while issuing reg 7: count stays 3
        bus.issue_dest = 3'd7;
        bus.wb_we      = 1'b1;
        bus.wb_load    = 1'b1;
        bus.wb_dest    = 3'd1;
        bus.wb_data    = 32'hC1;
        tick();
        checks++;
        if (bus.pend_cnt !== 4'd3) begin
            failures++;
            $display("FAIL b2b_swap got=%0d exp=3", bus.pend_cnt);
        end
        // port B stall blocks an issue to a free register
        idle();
        bus.rd_en_b    = 1'b1;
        bus.rd_addr_b  = 3'd2;
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd1;
        tick();
        checks++;
        if (bus.pend_cnt !== 4'd3) begin
            failures++;
            $display("FAIL b2b_portb_block got=%0d exp=3", bus.pend_cnt);
        end
        idle();
        for (int i = 2; i <= 7; i++) begin
            bus.wb_we   = 1'b1;
            bus.wb_load = 1'b1;
            bus.wb_dest = i[2:0];
            bus.wb_data = 32'hC0 + i;
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL b2b_drain got=%0d exp=0", bus.pend_cnt);
        end
    endtask

    task automatic test_r0();
        idle();
        bus.issue_load = 1'b1;
        bus.issue_dest = 3'd0;
        tick();
        idle();
        bus.wb_we     = 1'b1;
        bus.wb_dest   = 3'd0;
        bus.wb_data   = 32'hFF;
        bus.rd_addr_a = 3'd0;
        #1;
`ifdef R0_ZERO_EN
        checks++;
        if (bus.rd_data_a !== 32'd0 || bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL r0_bypass data=%h cnt=%0d exp 0/0", bus.rd_data_a, bus.pend_cnt);
        end
`else
        checks++;
        if (bus.rd_data_a !== 32'hFF || bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL r0_bypass data=%h cnt=%0d exp ff/1", bus.rd_data_a, bus.pend_cnt);
        end
`endif
        tick();
        idle();
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = 3'd0;
        #1;
`ifdef R0_ZERO_EN
        checks++;
        if (bus.rd_data_a !== 32'd0 || bus.stall !== 1'b0 || bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL r0_read data=%h stall=%b cnt=%0d exp 0/0/0", bus.rd_data_a, bus.stall, bus.pend_cnt);
        end
`else
        checks++;
        if (bus.rd_data_a !== 32'hFF || bus.stall !== 1'b1 || bus.pend_cnt !== 4'd1) begin
            failures++;
            $display("FAIL r0_read data=%h stall=%b cnt=%0d exp ff/1/1", bus.rd_data_a, bus.stall, bus.pend_cnt);
        end
`endif
        idle();
        bus.wb_we   = 1'b1;
        bus.wb_load = 1'b1;
        bus.wb_dest = 3'd0;
        bus.wb_data = 32'hFF;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pend_cnt !== 4'd0) begin
            failures++;
            $display("FAIL r0_drain cnt=%0d exp=0", bus.pend_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_load_use();
        test_collision();
        test_stall_gating();
        test_back_to_back();
        test_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
